// File: rtl/recepcao_pkg.sv
// recepcao_pkg: shared FSM encoding, frame constants and field widths for the serial receiver
package recepcao_pkg;
  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA, REGISTRA} estado_t;
  localparam logic       TIPO_FILA  = 1'b0;
  localparam logic [2:0] TIPO_CONT  = 3'b111;
  localparam int         LARG_FILA  = 6;
  localparam int         LARG_CONT  = 4;
  localparam int         FILA_DEPTH = 16;
  localparam int         CONT_DEPTH = 8;
  function automatic logic paridade_impar(input logic [6:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/recepcao_serial_automatica_rx.sv
// rx_serial_7O1: 7O1 deserialiser with input synchroniser, frame FSM and parity/stop check
module rx_serial_7O1
  import recepcao_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic [6:0] dados,
  output logic       pronto,
  output logic       erro_quadro
);
  localparam logic [15:0] MEIO = 16'(DIV / 2 - 1);
  localparam logic [15:0] BIT  = 16'(DIV - 1);
  estado_t     r_estado, w_prox;
  logic        r_rx_meta, r_rx_s, r_armado, r_par, r_stop, w_amostra;
  logic [15:0] r_tick;
  logic [2:0]  r_nbit;
  logic [6:0]  r_shift;
  assign w_amostra   = r_tick == ((r_estado == INICIO) ? MEIO : BIT);
  assign dados       = r_shift;
  assign pronto      = r_estado == REGISTRA;
  assign erro_quadro = pronto && (r_par != paridade_impar(r_shift) || !r_stop);
  // two-flop synchroniser, idles high
  always_ff @(posedge clock or negedge reset)
    if (!reset) {r_rx_meta, r_rx_s} <= 2'b11;
    else {r_rx_meta, r_rx_s} <= {RX, r_rx_meta};
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_estado <= OCIOSO;
    else r_estado <= w_prox;
  // next state: start needs the line to have been seen high since the last framing error
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:   if (!r_rx_s && r_armado) w_prox = INICIO;
      INICIO:   if (w_amostra) w_prox = r_rx_s ? OCIOSO : DADOS;
      DADOS:    if (w_amostra && r_nbit == 3'd6) w_prox = PARIDADE;
      PARIDADE: if (w_amostra) w_prox = PARADA;
      PARADA:   if (w_amostra) w_prox = REGISTRA;
      default:  w_prox = OCIOSO;
    endcase
  end
  // bit timing, LSB-first shift register, parity/stop capture and re-arm flag
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_tick   <= '0;
      r_nbit   <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_stop   <= 1'b0;
      r_armado <= 1'b1;
    end else begin
      r_tick <= (r_estado == OCIOSO || w_amostra) ? '0 : r_tick + 16'd1;
      if (r_estado == OCIOSO) r_nbit <= '0;
      if (r_estado == DADOS && w_amostra) begin
        r_shift <= {r_rx_s, r_shift[6:1]};
        r_nbit  <= r_nbit + 3'd1;
      end
      if (r_estado == PARIDADE && w_amostra) r_par <= r_rx_s;
      if (r_estado == PARADA && w_amostra) r_stop <= r_rx_s;
      if (r_rx_s) r_armado <= 1'b1;
      else if (r_estado == PARADA && w_amostra) r_armado <= 1'b0;
    end
endmodule

// File: rtl/recepcao_serial_automatica.sv
// recepcao_serial_automatica: classifies received frames into queue/content register files and counts errors
module recepcao_serial_automatica
  import recepcao_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 RX,
  input  logic                 limpa,
  input  logic [3:0]           addr_fila_rd,
  input  logic [2:0]           addr_cont_rd,
  output logic [LARG_FILA-1:0] dado_fila,
  output logic [LARG_CONT-1:0] dado_cont,
  output logic [3:0]           addr_fila_wr,
  output logic [2:0]           addr_cont_wr,
  output logic                 fila_cheia,
  output logic                 cont_cheio,
  output logic                 novo_fila,
  output logic                 novo_cont,
  output logic                 erro,
  output logic [7:0]           n_erros
);
  logic [6:0]           w_dados;
  logic                 w_pronto, w_erro_q, w_ok;
  logic [LARG_FILA-1:0] r_fila [FILA_DEPTH];
  logic [LARG_CONT-1:0] r_cont [CONT_DEPTH];
  logic [3:0]           r_addr_fila;
  logic [2:0]           r_addr_cont;
  logic                 r_fila_cheia, r_cont_cheio;
  logic [7:0]           r_n_erros;
  rx_serial_7O1 #(.DIV(DIV)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .RX         (RX),
    .dados      (w_dados),
    .pronto     (w_pronto),
    .erro_quadro(w_erro_q)
  );
  assign w_ok         = w_pronto && !w_erro_q;
  assign novo_fila    = w_ok && w_dados[6] == TIPO_FILA;
  assign novo_cont    = w_ok && w_dados[6:4] == TIPO_CONT;
  assign erro         = w_pronto && !novo_fila && !novo_cont;
  assign dado_fila    = r_fila[addr_fila_rd];
  assign dado_cont    = r_cont[addr_cont_rd];
  assign addr_fila_wr = r_addr_fila;
  assign addr_cont_wr = r_addr_cont;
  assign fila_cheia   = r_fila_cheia;
  assign cont_cheio   = r_cont_cheio;
  assign n_erros      = r_n_erros;
  // register files; writes use the pre-clear address even when limpa coincides
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < FILA_DEPTH; i++) r_fila[i] <= '0;
      for (int i = 0; i < CONT_DEPTH; i++) r_cont[i] <= '0;
    end else begin
      if (novo_fila) r_fila[r_addr_fila] <= w_dados[LARG_FILA-1:0];
      if (novo_cont) r_cont[r_addr_cont] <= w_dados[LARG_CONT-1:0];
    end
  // wrapping write addresses, sticky full flags and saturating error count; limpa wins
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_addr_fila  <= '0;
      r_addr_cont  <= '0;
      r_fila_cheia <= 1'b0;
      r_cont_cheio <= 1'b0;
      r_n_erros    <= '0;
    end else if (limpa) begin
      r_addr_fila  <= '0;
      r_addr_cont  <= '0;
      r_fila_cheia <= 1'b0;
      r_cont_cheio <= 1'b0;
      r_n_erros    <= '0;
    end else begin
      if (novo_fila) begin
        r_addr_fila <= r_addr_fila + 4'd1;
        if (r_addr_fila == 4'(FILA_DEPTH - 1)) r_fila_cheia <= 1'b1;
      end
      if (novo_cont) begin
        r_addr_cont <= r_addr_cont + 3'd1;
        if (r_addr_cont == 3'(CONT_DEPTH - 1)) r_cont_cheio <= 1'b1;
      end
      if (erro && r_n_erros != 8'hFF) r_n_erros <= r_n_erros + 8'd1;
    end
endmodule

// File: tb/tb_recepcao_serial_automatica.sv
// tb_recepcao_serial_automatica: scoreboard bench for the serial receive stage
module tb_recepcao_serial_automatica;
  localparam int DIV = 8;
  localparam logic [2:0] K_FILA = 3'b100, K_CONT = 3'b010, K_ERR = 3'b001, K_NADA = 3'b000;
  typedef struct {logic [2:0] kind; logic [3:0] af; logic [2:0] ac;} exp_t;
  logic clock = 0, reset = 1, RX = 1, limpa = 0;
  logic [3:0] addr_fila_rd = 0;
  logic [2:0] addr_cont_rd = 0;
  logic [5:0] dado_fila;
  logic [3:0] dado_cont, addr_fila_wr;
  logic [2:0] addr_cont_wr;
  logic fila_cheia, cont_cheio, novo_fila, novo_cont, erro;
  logic [7:0] n_erros;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  logic [3:0] m_af = 0;
  logic [2:0] m_ac = 0;

  recepcao_serial_automatica #(.DIV(DIV)) dut (
    .clock(clock), .reset(reset), .RX(RX), .limpa(limpa),
    .addr_fila_rd(addr_fila_rd), .addr_cont_rd(addr_cont_rd),
    .dado_fila(dado_fila), .dado_cont(dado_cont),
    .addr_fila_wr(addr_fila_wr), .addr_cont_wr(addr_cont_wr),
    .fila_cheia(fila_cheia), .cont_cheio(cont_cheio),
    .novo_fila(novo_fila), .novo_cont(novo_cont), .erro(erro), .n_erros(n_erros)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic odd(input logic [6:0] d);
    return ~^d;
  endfunction

  task automatic send(input logic [6:0] d, input logic p, input logic st, input logic [2:0] k, input int brk);
    logic [9:0] bits;
    if (k != K_NADA) sb.push_back(exp_t'{k, m_af, m_ac});
    if (k == K_FILA) m_af++;
    if (k == K_CONT) m_ac++;
    bits = {st, p, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      repeat (DIV) @(posedge clock);
    end
    RX = 0;
    repeat (brk) @(posedge clock);
    RX = 1;
    repeat (DIV) @(posedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clock);
    check("drain", 32'(sb.size()), 0);
    @(negedge clock);
  endtask

  task automatic rd_fila(input logic [3:0] a, input logic [5:0] e, input string tag);
    @(negedge clock);
    addr_fila_rd = a;
    #1 check(tag, 32'(dado_fila), 32'(e));
  endtask

  task automatic rd_cont(input logic [2:0] a, input logic [3:0] e, input string tag);
    @(negedge clock);
    addr_cont_rd = a;
    #1 check(tag, 32'(dado_cont), 32'(e));
  endtask

  // pops the expected event whenever the DUT pulses and checks type and write address
  always @(negedge clock) begin
    exp_t e;
    if (reset && (novo_fila || novo_cont || erro)) begin
      if (sb.size() == 0) check("spurious_event", 32'({novo_fila, novo_cont, erro}), 0);
      else begin
        e = sb.pop_front();
        check("event_kind", 32'({novo_fila, novo_cont, erro}), 32'(e.kind));
        if (novo_fila) check("event_addr_fila", 32'(addr_fila_wr), 32'(e.af));
        if (novo_cont) check("event_addr_cont", 32'(addr_cont_wr), 32'(e.ac));
      end
    end
  end

  initial begin
    #2 reset = 0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_addr_fila", 32'(addr_fila_wr), 0);
    check("rst_addr_cont", 32'(addr_cont_wr), 0);
    check("rst_flags", 32'({fila_cheia, cont_cheio, novo_fila, novo_cont, erro}), 0);
    check("rst_n_erros", 32'(n_erros), 0);
    check("rst_dado_fila", 32'(dado_fila), 0);
    @(negedge clock) reset = 1;
    repeat (4) @(posedge clock);
    send(7'h27, 1'b1, 1'b1, K_FILA, 0);
    drain();
    check("t1_addr_fila", 32'(addr_fila_wr), 1);
    check("t1_n_erros", 32'(n_erros), 0);
    rd_fila(0, 6'h27, "t1_fila0");
    send(7'h7A, 1'b0, 1'b1, K_CONT, 0);
    drain();
    check("t2_addr_cont", 32'(addr_cont_wr), 1);
    rd_cont(0, 4'hA, "t2_cont0");
    rd_fila(0, 6'h27, "t2_fila0_kept");
    rd_fila(1, 6'h00, "t2_fila1_empty");
    send(7'h27, 1'b0, 1'b1, K_ERR, 0);
    drain();
    check("t3_n_erros", 32'(n_erros), 1);
    check("t3_addr_fila", 32'(addr_fila_wr), 1);
    rd_fila(1, 6'h00, "t3_no_write");
    send(7'h50, 1'b1, 1'b1, K_ERR, 0);
    drain();
    check("t4_n_erros", 32'(n_erros), 2);
    check("t4_addr_cont", 32'(addr_cont_wr), 1);
    rd_cont(1, 4'h0, "t4_no_write");
    @(posedge clock) RX = 0;
    repeat (3) @(posedge clock);
    RX = 1;
    repeat (2 * DIV) @(posedge clock);
    check("glitch_n_erros", 32'(n_erros), 2);
    send(7'h15, odd(7'h15), 1'b1, K_FILA, 0);
    drain();
    rd_fila(1, 6'h15, "glitch_then_frame");
    send(7'h27, 1'b1, 1'b0, K_ERR, 12 * DIV);
    drain();
    check("break_n_erros", 32'(n_erros), 3);
    check("break_addr_fila", 32'(addr_fila_wr), 2);
    @(negedge clock) limpa = 1;
    @(negedge clock) limpa = 0;
    m_af = 0;
    m_ac = 0;
    #1;
    check("limpa_addrs", 32'({addr_fila_wr, addr_cont_wr}), 0);
    check("limpa_n_erros", 32'(n_erros), 0);
    rd_fila(0, 6'h27, "limpa_keeps_data");
    for (int i = 0; i < 8; i++) begin
      send(7'(8'h70 + i), odd(7'(8'h70 + i)), 1'b1, K_CONT, 0);
      drain();
      if (i == 6) check("t5_not_full_yet", 32'(cont_cheio), 0);
    end
    check("t5_cont_cheio", 32'(cont_cheio), 1);
    check("t5_addr_cont", 32'(addr_cont_wr), 0);
    rd_cont(7, 4'h7, "t5_cont7");
    rd_cont(0, 4'h0, "t5_cont0");
    send(7'h7F, 1'b0, 1'b1, K_CONT, 0);
    drain();
    rd_cont(0, 4'hF, "t5_overwrite");
    check("t5_still_full", 32'(cont_cheio), 1);
    check("t5_wrap_addr", 32'(addr_cont_wr), 1);
    send(7'h50, 1'b1, 1'b1, K_ERR, 0);
    drain();
    @(posedge clock) RX = 0;
    repeat (3 * DIV) @(posedge clock);
    RX = 1;
    @(negedge clock);
    #2 reset = 0;
    #1;
    check("mid_rst_cont", 32'({addr_cont_wr, cont_cheio}), 0);
    check("mid_rst_n_erros", 32'(n_erros), 0);
    check("mid_rst_dado_cont", 32'(dado_cont), 0);
    rd_fila(0, 6'h00, "mid_rst_fila0");
    @(negedge clock) reset = 1;
    m_af = 0;
    m_ac = 0;
    repeat (4 * DIV) @(posedge clock);
    check("mid_rst_quiet", 32'(n_erros), 0);
    send(7'h27, 1'b1, 1'b1, K_FILA, 0);
    drain();
    rd_fila(0, 6'h27, "post_rst_fila0");
    check("post_rst_addr", 32'(addr_fila_wr), 1);
    fork
      send(7'h33, odd(7'h33), 1'b1, K_FILA, 0);
      begin
        for (int i = 0; i < 400 && !novo_fila; i++) @(negedge clock);
        check("limpa_sync_seen", 32'(novo_fila), 1);
        limpa = 1;
        @(negedge clock) limpa = 0;
      end
    join
    m_af = 0;
    drain();
    check("limpa_sync_addr", 32'(addr_fila_wr), 0);
    rd_fila(1, 6'h33, "limpa_sync_write");
    repeat (5) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
